// File: rtl/riscv_cpu_pkg.sv
// Shared CPU front-end types: PC mux codes (also used by control_unit),
// the fetch NOP, fetch FSM states and the prefetch FIFO entry.
package riscv_cpu_pkg;
  localparam logic [1:0] CU_PC_NEXT   = 2'b00;
  localparam logic [1:0] CU_PC_JUMP   = 2'b01;
  localparam logic [1:0] CU_PC_BRANCH = 2'b10;

  localparam logic [31:0] IF_NOP = 32'h0000_0013;

  typedef enum logic {IF_IDLE, IF_REQ} if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_entry_t;
endpackage

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO of {instr, pc}; head is read straight from storage.
// A flush may coincide with a push, leaving only the pushed entry.
module if_prefetch_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int        DEPTH     = 2,
  parameter if_entry_t RST_ENTRY = '0,
  localparam int       AW        = $clog2(DEPTH),
  localparam int       CW        = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  if_entry_t     push_data,
  input  logic          pop,
  output if_entry_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  if_entry_t       mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;

  assign head  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
    end else if (flush) begin
      rptr <= '0;
      if (push) begin
        mem[0] <= push_data;
        wptr   <= AW'(1);
        count  <= CW'(1);
      end else begin
        wptr  <= '0;
        count <= '0;
      end
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The fetch credit scheme must never let a push land on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop && !flush));
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, req/gnt/rvalid memory port, prefetch FIFO, redirects.
// IF_MISALIGN_EXC_EN: misaligned redirect targets raise instr_misaligned_o.
module instr_fetch
  import riscv_cpu_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
`ifdef IF_MISALIGN_EXC_EN
  output logic        instr_misaligned_o,
`endif
  input  logic        instr_ready_i,
  input  logic [1:0]  pc_mux_i,
  input  logic [31:0] target_addr_i
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = CW + 4;

  if_state_e     state, state_n;
  logic [31:0]   fetch_pc, fetch_pc_n, pend_tgt, pend_tgt_n, rsp_pc, rsp_pc_n, tgt;
  logic          pend_v, pend_v_n, stall, stall_n;
  logic [CW-1:0] outs, outs_n, count, count_n;
  logic [DW-1:0] disc, disc_n;
  logic [CW:0]   used, used_n;
  logic          pop, push, redirect, mis, gnt, req_ok, full, empty;
  if_entry_t     head, push_data;

  assign tgt = {target_addr_i[31:2], 2'b00};
`ifdef IF_MISALIGN_EXC_EN
  assign mis = |target_addr_i[1:0];
  assign instr_misaligned_o = !empty && |head.pc[1:0];
`else
  logic unused_tgt_lsb;
  assign mis = 1'b0;
  assign unused_tgt_lsb = ^target_addr_i[1:0];
`endif

  assign redirect = (pc_mux_i == CU_PC_JUMP) || (pc_mux_i == CU_PC_BRANCH);
  assign pop      = !empty && instr_ready_i;
  assign used     = {1'b0, count} + {1'b0, outs};
  // A slot freed by this cycle's pop can already back a new request.
  assign req_ok   = used < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(pop));
  assign instr_req_o  = (state == IF_REQ) && req_ok;
  assign instr_addr_o = fetch_pc;
  assign gnt      = instr_req_o && instr_gnt_i;
  assign push     = redirect ? mis : (instr_rvalid_i && disc == '0);
  assign push_data = redirect ? '{instr: IF_NOP, pc: target_addr_i}
                              : '{instr: instr_rdata_i, pc: rsp_pc};

  assign instr_valid_o = !empty;
  assign instr_o       = head.instr;
  assign instr_pc_o    = head.pc;

  if_prefetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .RST_ENTRY ('{instr: IF_NOP, pc: BOOT_ADDR})
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .flush     (redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    pend_v_n   = pend_v;
    pend_tgt_n = pend_tgt;
    stall_n    = stall;
    outs_n     = outs;
    disc_n     = disc;
    rsp_pc_n   = rsp_pc;
    if (instr_rvalid_i) begin
      if (disc != '0) disc_n = disc - DW'(1);
      else            outs_n = outs - CW'(1);
    end
    if (gnt) begin
      if (pend_v) begin
        disc_n     = disc_n + DW'(1);
        fetch_pc_n = pend_tgt;
        pend_v_n   = 1'b0;
      end else begin
        outs_n     = outs_n + CW'(1);
        fetch_pc_n = fetch_pc + 32'd4;
      end
    end
    if (push && !redirect) rsp_pc_n = rsp_pc + 32'd4;
    if (redirect) begin
      // Everything still in flight becomes stale.
      disc_n   = disc_n + DW'(outs_n);
      outs_n   = '0;
      rsp_pc_n = tgt;
      stall_n  = mis;
      if (instr_req_o && !instr_gnt_i) begin
        pend_v_n   = 1'b1;
        pend_tgt_n = tgt;
      end else begin
        fetch_pc_n = tgt;
      end
    end
    count_n = redirect ? CW'(mis) : (count + CW'(push) - CW'(pop));
    used_n  = {1'b0, count_n} + {1'b0, outs_n};
    case (state)
      IF_IDLE: if (!stall_n && used_n < (CW+1)'(FIFO_DEPTH)) state_n = IF_REQ;
      IF_REQ: begin
        if (instr_req_o && !instr_gnt_i) state_n = IF_REQ;
        else if (stall_n) state_n = IF_IDLE;
        else if (gnt && used_n >= (CW+1)'(FIFO_DEPTH) && !instr_ready_i) state_n = IF_IDLE;
      end
      default: state_n = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IF_IDLE;
      fetch_pc <= BOOT_ADDR;
      rsp_pc   <= BOOT_ADDR;
      pend_tgt <= BOOT_ADDR;
      pend_v   <= 1'b0;
      stall    <= 1'b0;
      outs     <= '0;
      disc     <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      rsp_pc   <= rsp_pc_n;
      pend_tgt <= pend_tgt_n;
      pend_v   <= pend_v_n;
      stall    <= stall_n;
      outs     <= outs_n;
      disc     <= disc_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency memory model that returns
// the request address as data; a second instance checks PC wrap from a high boot address.
module tb_instr_fetch;
  import riscv_cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, instr_gnt_i, instr_rvalid_i, instr_ready_i;
  logic [31:0] instr_rdata_i, target_addr_i;
  logic [1:0]  pc_mux_i;
  logic        instr_req_o, instr_valid_o, hi_req, hi_valid;
  logic [31:0] instr_addr_o, instr_o, instr_pc_o, hi_addr, hi_instr, hi_pc;
`ifdef IF_MISALIGN_EXC_EN
  logic        instr_misaligned_o, hi_mis;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  logic        mv [0:3];
  logic [31:0] md [0:3];
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr, s_instr, s_pc, s_haddr, s_hpc;

  always #5 clk = ~clk;

  instr_fetch #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_o(instr_o), .instr_pc_o(instr_pc_o), .instr_valid_o(instr_valid_o),
`ifdef IF_MISALIGN_EXC_EN
    .instr_misaligned_o(instr_misaligned_o),
`endif
    .instr_ready_i(instr_ready_i), .pc_mux_i(pc_mux_i), .target_addr_i(target_addr_i)
  );

  instr_fetch #(.BOOT_ADDR(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_hi (
    .clk_i(clk), .rst_i(rst_i),
    .instr_req_o(hi_req), .instr_addr_o(hi_addr), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_o(hi_instr), .instr_pc_o(hi_pc), .instr_valid_o(hi_valid),
`ifdef IF_MISALIGN_EXC_EN
    .instr_misaligned_o(hi_mis),
`endif
    .instr_ready_i(instr_ready_i), .pc_mux_i(pc_mux_i), .target_addr_i(target_addr_i)
  );

  // One cycle: entered at a negedge with inputs already set; samples outputs
  // mid-cycle, advances the memory pipeline, returns at the next negedge.
  task tick();
    instr_rvalid_i = mv[0];
    instr_rdata_i  = md[0];
    #1;
    s_req = instr_req_o; s_addr = instr_addr_o; s_valid = instr_valid_o;
    s_instr = instr_o; s_pc = instr_pc_o; s_haddr = hi_addr; s_hpc = hi_pc;
`ifdef IF_MISALIGN_EXC_EN
    s_mis = instr_misaligned_o;
`else
    s_mis = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin mv[i] = mv[i+1]; md[i] = md[i+1]; end
    mv[3] = 1'b0;
    if (s_req && instr_gnt_i && !rst_i) begin
      mv[mem_lat-1] = 1'b1;
      md[mem_lat-1] = s_addr;
    end
    @(negedge clk);
  endtask

  task do_reset();
    for (int i = 0; i < 4; i++) begin mv[i] = 1'b0; md[i] = '0; end
    rst_i = 1'b1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
    pc_mux_i = CU_PC_NEXT; target_addr_i = '0;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task test_reset();
    do_reset();
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", s_req); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", s_valid); end
    checks++; if (s_instr !== IF_NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", s_instr, IF_NOP); end
    checks++; if (s_pc !== 32'h0 || s_addr !== 32'h0) begin errors++; $display("FAIL reset_pc got pc %h addr %h exp 0", s_pc, s_addr); end
    checks++; if (s_haddr !== 32'hFFFF_FFF8 || s_hpc !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL reset_boot got addr %h pc %h exp fffffff8", s_haddr, s_hpc); end
  endtask

  task test_stream();
    logic [31:0] e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k >= 1) begin
        e = 32'(4 * (k - 1));
        checks++; if (s_req !== 1'b1 || s_addr !== e) begin errors++; $display("FAIL stream_addr k=%0d got req %b addr %h exp 1 %h", k, s_req, s_addr, e); end
      end
      checks++; if (s_valid !== (k >= 3)) begin errors++; $display("FAIL stream_valid k=%0d got %b exp %b", k, s_valid, k >= 3); end
      if (k >= 3) begin
        e = 32'(4 * (k - 3));
        checks++; if (s_instr !== e || s_pc !== e) begin errors++; $display("FAIL stream_data k=%0d got instr %h pc %h exp %h", k, s_instr, s_pc, e); end
      end
      if (k >= 1 && k <= 3) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (k - 1));
        checks++; if (s_haddr !== e) begin errors++; $display("FAIL wrap_addr k=%0d got %h exp %h", k, s_haddr, e); end
      end
      if (k >= 3 && k <= 5) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (k - 3));
        checks++; if (s_hpc !== e) begin errors++; $display("FAIL wrap_pc k=%0d got %h exp %h", k, s_hpc, e); end
      end
    end
  endtask

  task test_backpressure();
    logic [31:0] exp_pc;
    int acc;
    exp_pc = '0; acc = 0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      instr_ready_i = (k >= 5);
      tick();
      if (k >= 3 && k <= 4) begin
        checks++; if (s_valid !== 1'b1 || s_instr !== 32'h0 || s_req !== 1'b0) begin
          errors++; $display("FAIL bp_hold k=%0d got valid %b instr %h req %b exp 1 0 0", k, s_valid, s_instr, s_req); end
      end
      if (k >= 5 && s_valid) begin
        checks++; if (s_pc !== exp_pc || s_instr !== exp_pc) begin
          errors++; $display("FAIL bp_order k=%0d got pc %h instr %h exp %h", k, s_pc, s_instr, exp_pc); end
        exp_pc += 32'd4; acc++;
      end
    end
    checks++; if (acc != 14) begin errors++; $display("FAIL bp_count got %0d exp 14", acc); end
    instr_ready_i = 1'b1;
  endtask

  task test_jump();
    do_reset();
    mem_lat = 2;
    target_addr_i = 32'h0000_0100;
    for (int k = 0; k < 10; k++) begin
      pc_mux_i = (k == 4) ? CU_PC_JUMP : CU_PC_NEXT;
      tick();
      if (k == 4) begin
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0) begin errors++; $display("FAIL jump_accept got valid %b pc %h exp 1 0", s_valid, s_pc); end
      end
      if (k == 5) begin
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL jump_addr got req %b addr %h exp 1 100", s_req, s_addr); end
      end
      if (k >= 5 && k <= 7) begin
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL jump_stale k=%0d got valid %b pc %h exp 0", k, s_valid, s_pc); end
      end
      if (k == 8 || k == 9) begin
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'(32'h100 + 4 * (k - 8)) || s_instr !== s_pc) begin
          errors++; $display("FAIL jump_new k=%0d got valid %b pc %h instr %h exp pc %h", k, s_valid, s_pc, s_instr, 32'(32'h100 + 4 * (k - 8))); end
      end
    end
    mem_lat = 1;
  endtask

  task test_redirect_pending();
    do_reset();
    target_addr_i = 32'h0000_0200;
    for (int k = 0; k < 11; k++) begin
      instr_gnt_i = !(k >= 3 && k <= 5);
      pc_mux_i = (k == 3) ? CU_PC_JUMP : CU_PC_NEXT;
      tick();
      if (k >= 3 && k <= 6) begin
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin errors++; $display("FAIL pend_hold k=%0d got req %b addr %h exp 1 8", k, s_req, s_addr); end
      end
      if (k == 7) begin
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL pend_target got req %b addr %h exp 1 200", s_req, s_addr); end
      end
      if (k >= 4 && k <= 8) begin
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL pend_stale k=%0d got valid %b pc %h exp 0", k, s_valid, s_pc); end
      end
      if (k == 9) begin
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h200) begin errors++; $display("FAIL pend_first got valid %b pc %h exp 1 200", s_valid, s_pc); end
      end
    end
    instr_gnt_i = 1'b1;
  endtask

`ifdef IF_MISALIGN_EXC_EN
  task test_misalign();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      pc_mux_i = (k == 3) ? CU_PC_BRANCH : (k == 7) ? CU_PC_JUMP : CU_PC_NEXT;
      target_addr_i = (k == 7) ? 32'h40 : 32'h102;
      instr_ready_i = !(k >= 4 && k <= 6);
      tick();
      if (k >= 4 && k <= 7) begin
        checks++; if (s_valid !== 1'b1 || s_mis !== 1'b1 || s_pc !== 32'h102 || s_instr !== IF_NOP || s_req !== 1'b0) begin
          errors++; $display("FAIL misalign k=%0d got valid %b mis %b pc %h instr %h req %b exp 1 1 102 %h 0", k, s_valid, s_mis, s_pc, s_instr, s_req, IF_NOP); end
      end
      if (k == 8) begin
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin errors++; $display("FAIL misalign_resume got req %b addr %h exp 1 40", s_req, s_addr); end
      end
    end
    instr_ready_i = 1'b1;
  endtask
`else
  task test_force_align();
    do_reset();
    target_addr_i = 32'h0000_010B;
    for (int k = 0; k < 8; k++) begin
      pc_mux_i = (k == 3) ? CU_PC_JUMP : CU_PC_NEXT;
      tick();
      if (k == 4) begin
        checks++; if (s_req !== 1'b1 || s_addr !== 32'h108) begin errors++; $display("FAIL align_addr got req %b addr %h exp 1 108", s_req, s_addr); end
      end
      if (k == 4 || k == 5) begin
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL align_stale k=%0d got valid %b exp 0", k, s_valid); end
      end
      if (k == 6) begin
        checks++; if (s_valid !== 1'b1 || s_pc !== 32'h108 || s_mis !== 1'b0) begin errors++; $display("FAIL align_first got valid %b pc %h exp 1 108", s_valid, s_pc); end
      end
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; instr_gnt_i = 1'b1; instr_ready_i = 1'b1;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0;
    pc_mux_i = CU_PC_NEXT; target_addr_i = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_redirect_pending();
`ifdef IF_MISALIGN_EXC_EN
    test_misalign();
`else
    test_force_align();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage sitting directly upstream of control_unit. Owns the program counter and issues requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned words, with their PCs, in a small prefetch FIFO and presents them to decode through a valid/ready handshake.
- Applies PC redirects (jump/branch) selected by the decode-stage pc_mux code, flushing stale in-flight fetches.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0)
- FIFO_DEPTH, 2, prefetch FIFO entries and max outstanding requests (power of 2, >=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- instr_req_o  out  1  memory request
- instr_addr_o  out  32  request address (word aligned)
- instr_gnt_i  in  1  request accepted
- instr_rvalid_i  in  1  response valid (in order, >=1 cycle after gnt)
- instr_rdata_i  in  32  response word
- instr_o  out  32  instruction to decode
- instr_pc_o  out  32  PC of instr_o
- instr_valid_o  out  1  instr_o valid
- instr_ready_i  in  1  decode accepts instr_o
- pc_mux_i  in  2  CU_PC_NEXT / CU_PC_JUMP / CU_PC_BRANCH; 2'b11 reserved = NEXT
- target_addr_i  in  32  redirect target

Behaviour:
- Reset values (synchronous, rst_i high at posedge):
  - instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=IF_NOP (32'h0000_0013), instr_pc_o=BOOT_ADDR.
  - FIFO empty, outstanding=0, discard=0, FSM=IDLE.
  - Reset mid-transaction drops all pending responses; memory must be reset alongside.
- FSM states:
  - IDLE: req=0. Go to REQ when credits = FIFO_DEPTH - (occupancy + outstanding) > 0; first REQ is the cycle after reset release.
  - REQ: req=1, addr=fetch_pc. On gnt: outstanding+1 and fetch_pc+=4 (wraps 32'hFFFF_FFFC->0). Stay in REQ if credits remain after this grant, else go to IDLE.
- Address stability: while req=1 and gnt=0, addr and req must not change, even on redirect.
- Redirect when pc_mux_i is JUMP or BRANCH:
  - Decode issues it in the same cycle it accepts the instruction.
  - In that cycle: FIFO cleared. discard += outstanding, plus 1 if a gnt occurs this cycle, minus 1 if an rvalid occurs this cycle.
  - fetch_pc = {target_addr_i[31:2],2'b00} if no request is pending. Otherwise the target is latched in pend_target and applied after gnt, and the granted request is counted for discard.
  - instr_valid_o=0 the next cycle. First redirected instruction visible >=2 cycles after its rvalid-free request cycle: minimum redirect-to-valid latency = 1 (req) + memory latency + 1.
- Responses:
  - An rvalid with discard>0 decrements discard; the word is dropped.
  - Otherwise push {rdata, pc} into the FIFO and decrement outstanding.
  - A response arriving in the redirect cycle is dropped.
- FIFO:
  - Output registered from the head; instr_valid_o = !empty.
  - Pop on valid&&ready; push and pop in the same cycle allowed when full.
  - Push while full without pop cannot happen (credit scheme); assertion required.
- Throughput: one instruction per cycle sustained when gnt is tied high and memory latency is 1.
- instr_o / instr_pc_o hold value while valid=1 and ready=0.

Optional Feature:
- Macro: IF_MISALIGN_EXC_EN.
- Defined:
  - Adds output instr_misaligned_o (1).
  - A redirect with target_addr_i[1:0]!=0 does not fetch. The FIFO presents one entry {IF_NOP, raw target} with misaligned=1.
  - The stage then stalls (no req) until the next redirect.
- Undefined:
  - Port absent; target bits [1:0] silently forced to 0.

Decomposition:
- riscv_cpu_pkg: CU_PC_NEXT/JUMP/BRANCH constants (shared with control_unit), IF_NOP, if_state_e enum, if_entry_t struct {instr, pc}.
- Sub-module if_prefetch_fifo: parameterised synchronous FIFO of if_entry_t, with push/pop/flush/full/empty/count.

Test Plan:
- Reset release, gnt=1, 1-cycle memory returning addr as data, ready=1:
  - Addresses 0x0,0x4,0x8…; instr_o==instr_pc_o each cycle; valid from cycle 2 onward without gaps.
- ready=0 for 5 cycles:
  - FIFO fills to 2, req drops, outstanding 0, instr_o stable at 0x0.
  - Resume: no loss or duplicate.
- JUMP to 0x100 with 2 outstanding:
  - Both stale responses dropped; next valid has pc 0x100.
- Redirect while req pending and gnt delayed 3 cycles:
  - addr stays 0x8 until gnt, that response is discarded, the next req addr is the target.
- BOOT_ADDR=32'hFFFF_FFF8:
  - PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- IF_MISALIGN_EXC_EN defined, BRANCH to 0x102:
  - instr_misaligned_o=1, instr_pc_o=0x102, no req until the next redirect.
